// File: rtl/muxn_pkg.sv
// Shared definitions for the muxn_arb registered N:1 multiplexer/arbiter:
// select-width helper and run-time mode encodings.
package muxn_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Index width for n channels; never narrower than one bit.
    function automatic int sel_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/muxn_arb_rr_arbiter.sv
// Round-robin request arbiter for muxn_arb; MUXN_FIXED_PRIO_EN selects a
// fixed lowest-index-wins variant that ignores the pointer.
module rr_arbiter
    import muxn_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = sel_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            enable,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx,
    output logic            any_grant
);

`ifdef MUXN_FIXED_PRIO_EN
    logic unused_ptr_s;

    assign unused_ptr_s = ^ptr;

    // Lowest-index requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        if (enable) begin
            for (int i = 0; i < N; i++) begin
                if (!any_grant && req[i]) begin
                    any_grant = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = SELW'(i);
                end else begin
                    any_grant = any_grant;
                end
            end
        end else begin
            any_grant = 1'b0;
        end
    end
`else
    // Search starts just after the last accepted channel and wraps modulo N.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        if (enable) begin
            for (int k = 1; k <= N; k++) begin
                idx = (int'(ptr) + k) % N;
                if (!any_grant && req[idx]) begin
                    any_grant  = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = SELW'(idx);
                end else begin
                    any_grant = any_grant;
                end
            end
        end else begin
            any_grant = 1'b0;
        end
    end
`endif

endmodule

// File: rtl/muxn_arb.sv
// N-input registered multiplexer with valid/ready handshakes, manual or
// round-robin selection. MUXN_FIXED_PRIO_EN turns round-robin into fixed priority.
module muxn_arb
    import muxn_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int SELW = sel_width(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SELW-1:0] sel_man,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_sel,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [N-1:0]    man_grant_s;
    logic            man_any_s;
    logic [N-1:0]    rr_grant_s;
    logic [SELW-1:0] rr_idx_s;
    logic            rr_any_s;
    logic [N-1:0]    grant_s;
    logic [SELW-1:0] win_idx_s;
    logic            any_grant_s;
    logic [W-1:0]    win_data_s;
    logic            load_possible_s;
    logic            load_s;
    logic [SELW-1:0] ptr_s;

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0] out_sel_q,   out_sel_d;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (ptr_s),
        .enable    (mode == MODE_RR),
        .grant     (rr_grant_s),
        .grant_idx (rr_idx_s),
        .any_grant (rr_any_s)
    );

    // Manual grant; an out-of-range sel_man matches no channel.
    always_comb begin
        man_grant_s = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_man == SELW'(i)) begin
                man_grant_s[i] = in_valid[i];
            end else begin
                man_grant_s[i] = 1'b0;
            end
        end
        man_any_s = |man_grant_s;
    end

    // Mode steering and winner data extraction.
    always_comb begin
        win_data_s = '0;
        if (mode == MODE_RR) begin
            grant_s     = rr_grant_s;
            win_idx_s   = rr_idx_s;
            any_grant_s = rr_any_s;
        end else begin
            grant_s     = man_grant_s;
            win_idx_s   = sel_man;
            any_grant_s = man_any_s;
        end
        for (int i = 0; i < N; i++) begin
            if (grant_s[i]) begin
                win_data_s = in_data[i*W +: W];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    assign load_possible_s = !out_valid_q || out_ready;
    assign load_s          = load_possible_s && any_grant_s;

    // Accept strobes, held low throughout reset.
    always_comb begin
        in_ready = '0;
        if (rst_n && load_possible_s) begin
            in_ready = grant_s;
        end else begin
            in_ready = '0;
        end
    end

    // Output register next state: load, drain, or hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load_s) begin
            out_valid_d = 1'b1;
            out_data_d  = win_data_s;
            out_sel_d   = win_idx_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

`ifdef MUXN_FIXED_PRIO_EN
    assign ptr_s = SELW'(N - 1);
`else
    logic [SELW-1:0] ptr_q, ptr_d;

    // Pointer follows the winner only on accepted round-robin transfers.
    always_comb begin
        ptr_d = ptr_q;
        if (load_s && (mode == MODE_RR)) begin
            ptr_d = win_idx_s;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register; reset value gives channel 0 first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= SELW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_s = ptr_q;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_muxn_arb.sv
// Table-driven bench for muxn_arb (N=4, W=8, SELW=3) with an expected-output queue.
module tb_muxn_arb;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int SELW = 3;

    localparam logic        RR  = 1'b1;
    localparam logic        MAN = 1'b0;
    localparam logic [31:0] D1  = 32'h4433_2211;
    localparam logic [31:0] D2  = 32'h0D0C_0B0A;

    typedef struct {
        logic        mode;
        logic [2:0]  sel;
        logic [3:0]  valid;
        logic        ordy;
        logic [31:0] data;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [7:0]  exp_od;
        logic [2:0]  exp_os;
    } vec_t;

    typedef struct {
        logic       ov;
        logic [7:0] od;
        logic [2:0] os;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SELW-1:0] sel_man;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_sel;
    logic            out_valid;
    logic            out_ready;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];
    exp_t sbq[$];

    muxn_arb #(.N(N), .W(W), .SELW(SELW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel_man   (sel_man),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic m, input logic [2:0] s, input logic [3:0] vld,
                                input logic o, input logic [31:0] d, input logic [3:0] r,
                                input logic ov, input logic [7:0] od, input logic [2:0] os);
        vec_t v;
        v.mode = m; v.sel = s; v.valid = vld; v.ordy = o; v.data = d;
        v.exp_rdy = r; v.exp_ov = ov; v.exp_od = od; v.exp_os = os;
        return v;
    endfunction

    // Drive one vector, check in_ready, queue the post-edge expectation, then check it.
    task automatic apply(input string tag, input vec_t v);
        exp_t e;
        mode      = v.mode;
        sel_man   = v.sel;
        in_valid  = v.valid;
        out_ready = v.ordy;
        in_data   = v.data;
        #2;
        chk({tag, " in_ready"}, 32'(in_ready), 32'(v.exp_rdy));
        sbq.push_back('{v.exp_ov, v.exp_od, v.exp_os});
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
        end else begin
            e = sbq.pop_front();
            chk({tag, " out_valid"}, 32'(out_valid), 32'(e.ov));
            chk({tag, " out_data"},  32'(out_data),  32'(e.od));
            chk({tag, " out_sel"},   32'(out_sel),   32'(e.os));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = RR;
        sel_man   = 3'd0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data   = D1;

        // Round-robin from reset, ptr starts at 3 so channel 0 goes first.
        vecs.push_back(mk(RR, 3'd0, 4'b1111, 1'b1, D1, 4'b0001, 1'b1, 8'h11, 3'd0));
        vecs.push_back(mk(RR, 3'd0, 4'b1111, 1'b1, D1, 4'b0010, 1'b1, 8'h22, 3'd1));
        vecs.push_back(mk(RR, 3'd0, 4'b1111, 1'b1, D1, 4'b0100, 1'b1, 8'h33, 3'd2));
        vecs.push_back(mk(RR, 3'd0, 4'b1111, 1'b1, D1, 4'b1000, 1'b1, 8'h44, 3'd3));
        vecs.push_back(mk(RR, 3'd0, 4'b1111, 1'b1, D1, 4'b0001, 1'b1, 8'h11, 3'd0));
        // Manual select cycling, then 3 cycles of backpressure holding 0x0C.
        vecs.push_back(mk(MAN, 3'd0, 4'b1111, 1'b1, D2, 4'b0001, 1'b1, 8'h0A, 3'd0));
        vecs.push_back(mk(MAN, 3'd1, 4'b1111, 1'b1, D2, 4'b0010, 1'b1, 8'h0B, 3'd1));
        vecs.push_back(mk(MAN, 3'd2, 4'b1111, 1'b1, D2, 4'b0100, 1'b1, 8'h0C, 3'd2));
        vecs.push_back(mk(MAN, 3'd3, 4'b1111, 1'b0, D2, 4'b0000, 1'b1, 8'h0C, 3'd2));
        vecs.push_back(mk(MAN, 3'd3, 4'b1111, 1'b0, D2, 4'b0000, 1'b1, 8'h0C, 3'd2));
        vecs.push_back(mk(MAN, 3'd3, 4'b1111, 1'b0, D2, 4'b0000, 1'b1, 8'h0C, 3'd2));
        vecs.push_back(mk(MAN, 3'd3, 4'b1111, 1'b1, D2, 4'b1000, 1'b1, 8'h0D, 3'd3));
        // Out-of-range manual select: no grant, output drains and holds data.
        vecs.push_back(mk(MAN, 3'd5, 4'b1111, 1'b1, D2, 4'b0000, 1'b0, 8'h0D, 3'd3));
        vecs.push_back(mk(MAN, 3'd5, 4'b1111, 1'b1, D2, 4'b0000, 1'b0, 8'h0D, 3'd3));
        // Sparse round-robin (ptr still 0): 1,3,1 then channel 3 drops.
        vecs.push_back(mk(RR, 3'd0, 4'b1010, 1'b1, D1, 4'b0010, 1'b1, 8'h22, 3'd1));
        vecs.push_back(mk(RR, 3'd0, 4'b1010, 1'b1, D1, 4'b1000, 1'b1, 8'h44, 3'd3));
        vecs.push_back(mk(RR, 3'd0, 4'b1010, 1'b1, D1, 4'b0010, 1'b1, 8'h22, 3'd1));
        vecs.push_back(mk(RR, 3'd0, 4'b0010, 1'b1, D1, 4'b0010, 1'b1, 8'h22, 3'd1));
        vecs.push_back(mk(RR, 3'd0, 4'b0010, 1'b1, D1, 4'b0010, 1'b1, 8'h22, 3'd1));
        // Mode switch while held must not disturb the output.
        vecs.push_back(mk(RR,  3'd0, 4'b1111, 1'b0, D1, 4'b0000, 1'b1, 8'h22, 3'd1));
        vecs.push_back(mk(MAN, 3'd0, 4'b1111, 1'b0, D1, 4'b0000, 1'b1, 8'h22, 3'd1));
        vecs.push_back(mk(MAN, 3'd0, 4'b1111, 1'b1, D1, 4'b0001, 1'b1, 8'h11, 3'd0));
        vecs.push_back(mk(RR,  3'd0, 4'b1111, 1'b1, D1, 4'b0100, 1'b1, 8'h33, 3'd2));
        vecs.push_back(mk(RR,  3'd0, 4'b0000, 1'b1, D1, 4'b0000, 1'b0, 8'h33, 3'd2));
        vecs.push_back(mk(RR,  3'd0, 4'b1111, 1'b1, D1, 4'b1000, 1'b1, 8'h44, 3'd3));
        vecs.push_back(mk(RR,  3'd0, 4'b1111, 1'b0, D1, 4'b0000, 1'b1, 8'h44, 3'd3));

        #3;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data",  32'(out_data),  32'd0);
        chk("reset out_sel",   32'(out_sel),   32'd0);
        chk("reset in_ready",  32'(in_ready),  32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("v%0d", i), vecs[i]);
        end

        // Reset mid-hold clears the output without a clock edge.
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst out_data",  32'(out_data),  32'd0);
        chk("midrst out_sel",   32'(out_sel),   32'd0);
        chk("midrst in_ready",  32'(in_ready),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply("post_rst0", mk(RR, 3'd0, 4'b1111, 1'b1, D1, 4'b0001, 1'b1, 8'h11, 3'd0));
        apply("post_rst1", mk(RR, 3'd0, 4'b1111, 1'b1, D1, 4'b0010, 1'b1, 8'h22, 3'd1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
